// File: rtl/cpu_exec_pkg.sv
// rtl/cpu_exec_pkg.sv - shared opcode, operand-select and address-mode encodings
package cpu_exec_pkg;

  // ALU opcodes driven by the control unit
  localparam logic [3:0] OP_PASS = 4'd0;
  localparam logic [3:0] OP_ADD  = 4'd1;
  localparam logic [3:0] OP_SUB  = 4'd2;
  localparam logic [3:0] OP_AND  = 4'd3;
  localparam logic [3:0] OP_OR   = 4'd4;
  localparam logic [3:0] OP_XOR  = 4'd5;
  localparam logic [3:0] OP_NOT  = 4'd6;
  localparam logic [3:0] OP_SHL  = 4'd7;
  localparam logic [3:0] OP_SHR  = 4'd8;
  localparam logic [3:0] OP_ADC  = 4'd9;
  localparam logic [3:0] OP_SBC  = 4'd10;
  localparam logic [3:0] OP_INC  = 4'd11;
  localparam logic [3:0] OP_DEC  = 4'd12;
  localparam logic [3:0] OP_ROL  = 4'd13;
  localparam logic [3:0] OP_ROR  = 4'd14;
  localparam logic [3:0] OP_CMP  = 4'd15;

  // Operand-B sources
  localparam logic [1:0] BSEL_IMM  = 2'd0;
  localparam logic [1:0] BSEL_REG  = 2'd1;
  localparam logic [1:0] BSEL_MEM  = 2'd2;
  localparam logic [1:0] BSEL_ZERO = 2'd3;

  // Data-memory addressing modes
  localparam logic AMODE_DIR = 1'b0;
  localparam logic AMODE_IND = 1'b1;

endpackage

// File: rtl/cpu_exec_alu.sv
// rtl/cpu_exec_alu.sv - combinational ALU: result and carry/borrow from A, B, C_IN
module cpu_alu
  import cpu_exec_pkg::*;
#(
  parameter int DWIDTH  = 8,
  parameter int OPWIDTH = 4
) (
  input  logic [OPWIDTH-1:0] op,
  input  logic [DWIDTH-1:0]  a,
  input  logic [DWIDTH-1:0]  b,
  input  logic               c_in,
  output logic [DWIDTH-1:0]  r,
  output logic               c_out
);

  localparam logic [DWIDTH:0] ONE = 1;

  logic [DWIDTH:0] a_ext;
  logic [DWIDTH:0] b_ext;
  logic [DWIDTH:0] c_ext;
  logic [DWIDTH:0] wide;

  assign a_ext = {1'b0, a};
  assign b_ext = {1'b0, b};
  assign c_ext = {{DWIDTH{1'b0}}, c_in};

  // Arithmetic runs one bit wider so the top bit is the carry or borrow
  always_comb begin
    wide  = '0;
    r     = b;
    c_out = c_in;
    case (op)
      OP_PASS: begin
        r = b;
      end
      OP_ADD: begin
        wide  = a_ext + b_ext;
        r     = wide[DWIDTH-1:0];
        c_out = wide[DWIDTH];
      end
      OP_SUB, OP_CMP: begin
        wide  = a_ext - b_ext;
        r     = wide[DWIDTH-1:0];
        c_out = wide[DWIDTH];
      end
      OP_AND: r = a & b;
      OP_OR:  r = a | b;
      OP_XOR: r = a ^ b;
      OP_NOT: r = ~a;
      OP_SHL: begin
        r     = {a[DWIDTH-2:0], 1'b0};
        c_out = a[DWIDTH-1];
      end
      OP_SHR: begin
        r     = {1'b0, a[DWIDTH-1:1]};
        c_out = a[0];
      end
      OP_ADC: begin
        wide  = a_ext + b_ext + c_ext;
        r     = wide[DWIDTH-1:0];
        c_out = wide[DWIDTH];
      end
      OP_SBC: begin
        wide  = a_ext - b_ext - c_ext;
        r     = wide[DWIDTH-1:0];
        c_out = wide[DWIDTH];
      end
      OP_INC: begin
        wide  = a_ext + ONE;
        r     = wide[DWIDTH-1:0];
        c_out = wide[DWIDTH];
      end
      OP_DEC: begin
        wide  = a_ext - ONE;
        r     = wide[DWIDTH-1:0];
        c_out = wide[DWIDTH];
      end
      OP_ROL: begin
        r     = {a[DWIDTH-2:0], c_in};
        c_out = a[DWIDTH-1];
      end
      OP_ROR: begin
        r     = {c_in, a[DWIDTH-1:1]};
        c_out = a[0];
      end
      default: begin
        r     = b;
        c_out = c_in;
      end
    endcase
  end

endmodule

// File: rtl/cpu_exec.sv
// rtl/cpu_exec.sv - execution datapath: accumulator, flags, register file, data memory
module cpu_exec
  import cpu_exec_pkg::*;
#(
  parameter int DWIDTH         = 8,
  parameter int OPWIDTH        = 4,
  parameter int REG_F_SEL_SIZE = 4,
  parameter int IN_B_SEL_SIZE  = 2,
  parameter int DMEM_DEPTH     = 256
) (
  input  logic                      CLK,
  input  logic                      RST_N,
  input  logic [OPWIDTH-1:0]        ALU_OUT,
  input  logic [DWIDTH-1:0]         IMM,
  input  logic [IN_B_SEL_SIZE-1:0]  IN_B_SEL,
  input  logic [REG_F_SEL_SIZE-1:0] REG_F_SEL,
  input  logic                      EN_REG_F,
  input  logic [DWIDTH-1:0]         D_MEM_ADDR,
  input  logic                      D_MEM_ADDR_MODE,
  input  logic                      EN_D_MEM,
  input  logic                      EN_ACC,
  output logic [DWIDTH-1:0]         ACC_OUT,
  output logic                      FLAG_Z,
  output logic                      FLAG_C
);

  localparam int NREGS = 2 ** REG_F_SEL_SIZE;

  logic [DWIDTH-1:0] acc;
  logic              flag_z;
  logic              flag_c;
  logic [DWIDTH-1:0] regs [NREGS];
  logic [DWIDTH-1:0] dmem [DMEM_DEPTH];

  logic [DWIDTH-1:0] reg_rd;
  logic [DWIDTH-1:0] eff_addr;
  logic [DWIDTH-1:0] operand_b;
  logic [DWIDTH-1:0] alu_r;
  logic              alu_c;

  // Reads are combinational from pre-edge state, so every same-cycle write sees old values
  assign reg_rd   = regs[REG_F_SEL];
  assign eff_addr = (D_MEM_ADDR_MODE == AMODE_IND) ? reg_rd : D_MEM_ADDR;

  // Operand-B source mux
  always_comb begin
    operand_b = '0;
    case (IN_B_SEL)
      BSEL_IMM:  operand_b = IMM;
      BSEL_REG:  operand_b = reg_rd;
      BSEL_MEM:  operand_b = dmem[eff_addr];
      BSEL_ZERO: operand_b = '0;
      default:   operand_b = '0;
    endcase
  end

  cpu_alu #(
    .DWIDTH  (DWIDTH),
    .OPWIDTH (OPWIDTH)
  ) u_alu (
    .op    (ALU_OUT),
    .a     (acc),
    .b     (operand_b),
    .c_in  (flag_c),
    .r     (alu_r),
    .c_out (alu_c)
  );

  // Accumulator and flags; CMP updates flags only
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      acc    <= '0;
      flag_z <= 1'b0;
      flag_c <= 1'b0;
    end else if (EN_ACC) begin
      if (ALU_OUT != OP_CMP) begin
        acc <= alu_r;
      end
      flag_z <= (alu_r == '0);
      flag_c <= alu_c;
    end
  end

  // Register file stores the pre-edge accumulator
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (EN_REG_F) begin
      regs[REG_F_SEL] <= acc;
    end
  end

  // Data memory has no reset but must not be written while reset is held
  always_ff @(posedge CLK) begin
    if (RST_N && EN_D_MEM) begin
      dmem[eff_addr] <= acc;
    end
  end

  assign ACC_OUT = acc;
  assign FLAG_Z  = flag_z;
  assign FLAG_C  = flag_c;

endmodule

// File: tb/tb_cpu_exec.sv
// tb/tb_cpu_exec.sv - scoreboard bench for cpu_exec against an arithmetic reference model
module tb_cpu_exec;
  import cpu_exec_pkg::*;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b1;
  logic [3:0] ALU_OUT = '0;
  logic [7:0] IMM = '0;
  logic [1:0] IN_B_SEL = '0;
  logic [3:0] REG_F_SEL = '0;
  logic       EN_REG_F = 1'b0;
  logic [7:0] D_MEM_ADDR = '0;
  logic       D_MEM_ADDR_MODE = 1'b0;
  logic       EN_D_MEM = 1'b0;
  logic       EN_ACC = 1'b0;
  logic [7:0] ACC_OUT;
  logic       FLAG_Z;
  logic       FLAG_C;

  cpu_exec dut (
    .CLK             (CLK),
    .RST_N           (RST_N),
    .ALU_OUT         (ALU_OUT),
    .IMM             (IMM),
    .IN_B_SEL        (IN_B_SEL),
    .REG_F_SEL       (REG_F_SEL),
    .EN_REG_F        (EN_REG_F),
    .D_MEM_ADDR      (D_MEM_ADDR),
    .D_MEM_ADDR_MODE (D_MEM_ADDR_MODE),
    .EN_D_MEM        (EN_D_MEM),
    .EN_ACC          (EN_ACC),
    .ACC_OUT         (ACC_OUT),
    .FLAG_Z          (FLAG_Z),
    .FLAG_C          (FLAG_C)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [7:0] acc;
    logic       z;
    logic       c;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  bit   active = 1'b0;

  int m_acc;
  bit m_z;
  bit m_c;
  int m_reg[16];
  int m_mem[256];

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_acc = 0;
    m_z = 1'b0;
    m_c = 1'b0;
    for (int i = 0; i < 16; i++) m_reg[i] = 0;
  endtask

  // Monitor: every issued cycle yields one post-edge observation
  always @(posedge CLK) begin
    if (active) begin
      exp_t e;
      #1;
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL scoreboard: DUT cycle with no expected entry, acc=0x%0h", ACC_OUT);
      end else begin
        e = exp_q.pop_front();
        if ({ACC_OUT, FLAG_Z, FLAG_C} !== {e.acc, e.z, e.c}) begin
          fails++;
          $display("FAIL acc/z/c: got acc=0x%0h z=%0b c=%0b expected acc=0x%0h z=%0b c=%0b",
                   ACC_OUT, FLAG_Z, FLAG_C, e.acc, e.z, e.c);
        end
      end
    end
  end

  // Apply one control word and push the expected post-edge ACC/flags
  task automatic drive(input int op, input int imm, input int bsel, input int sel,
                       input bit en_reg, input int addr, input bit mode,
                       input bit en_mem, input bit en_acc);
    int a, b, r, eff;
    bit cn;
    exp_t e;
    @(negedge CLK);
    ALU_OUT = op[3:0];
    IMM = imm[7:0];
    IN_B_SEL = bsel[1:0];
    REG_F_SEL = sel[3:0];
    EN_REG_F = en_reg;
    D_MEM_ADDR = addr[7:0];
    D_MEM_ADDR_MODE = mode;
    EN_D_MEM = en_mem;
    EN_ACC = en_acc;
    active = 1'b1;

    a = m_acc;
    eff = mode ? m_reg[sel] : addr;
    case (bsel)
      0: b = imm;
      1: b = m_reg[sel];
      2: b = m_mem[eff];
      default: b = 0;
    endcase
    cn = m_c;
    r = b;
    case (op)
      0:  r = b;
      1:  begin r = (a + b) % 256; cn = (a + b) > 255; end
      2:  begin r = (a - b + 256) % 256; cn = a < b; end
      3:  r = a & b;
      4:  r = a | b;
      5:  r = a ^ b;
      6:  r = 255 - a;
      7:  begin r = (a * 2) % 256; cn = a >= 128; end
      8:  begin r = a / 2; cn = (a % 2) == 1; end
      9:  begin r = (a + b + int'(m_c)) % 256; cn = (a + b + int'(m_c)) > 255; end
      10: begin r = (a - b - int'(m_c) + 512) % 256; cn = a < (b + int'(m_c)); end
      11: begin r = (a + 1) % 256; cn = a == 255; end
      12: begin r = (a + 255) % 256; cn = a == 0; end
      13: begin r = (a * 2) % 256 + int'(m_c); cn = a >= 128; end
      14: begin r = a / 2 + (m_c ? 128 : 0); cn = (a % 2) == 1; end
      default: begin r = (a - b + 256) % 256; cn = a < b; end
    endcase

    if (en_reg) m_reg[sel] = a;
    if (en_mem) m_mem[eff] = a;
    if (en_acc) begin
      if (op != 15) m_acc = r;
      m_z = (r == 0);
      m_c = cn;
    end
    e.acc = m_acc[7:0];
    e.z = m_z;
    e.c = m_c;
    exp_q.push_back(e);
  endtask

  task automatic idle();
    @(negedge CLK);
    EN_ACC = 1'b0;
    EN_REG_F = 1'b0;
    EN_D_MEM = 1'b0;
    active = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge CLK);

    // Reset pulse entirely between edges
    #2 RST_N = 1'b0;
    #1;
    chk("reset_acc", int'(ACC_OUT), 0);
    chk("reset_z", int'(FLAG_Z), 0);
    chk("reset_c", int'(FLAG_C), 0);
    #1 RST_N = 1'b1;
    model_reset();

    // Every register reads zero after reset
    for (int i = 0; i < 16; i++) drive(OP_PASS, 0, BSEL_REG, i, 0, 0, AMODE_DIR, 0, 1);

    // Fill data memory so every later read has a known value
    for (int i = 0; i < 256; i++)
      drive(OP_PASS, int'($urandom_range(0, 255)), BSEL_IMM, 0, 0, i, AMODE_DIR, 1, 1);

    // Add wrap-around, then add-with-carry
    drive(OP_PASS, 'h7F, BSEL_IMM, 0, 0, 0, AMODE_DIR, 0, 1);
    drive(OP_ADD,  'h81, BSEL_IMM, 0, 0, 0, AMODE_DIR, 0, 1);
    drive(OP_ADC,  'h00, BSEL_IMM, 0, 0, 0, AMODE_DIR, 0, 1);

    // Direct memory write then read back
    drive(OP_PASS, 'h5A, BSEL_IMM, 0, 0, 0,    AMODE_DIR, 0, 1);
    drive(OP_PASS, 'h00, BSEL_IMM, 0, 0, 'h10, AMODE_DIR, 1, 1);
    drive(OP_PASS, 'h00, BSEL_MEM, 0, 0, 'h10, AMODE_DIR, 0, 1);

    // Indirect write through REG[3] then direct read
    drive(OP_PASS, 'h20, BSEL_IMM, 0, 0, 0,    AMODE_DIR, 0, 1);
    drive(OP_PASS, 'hC3, BSEL_IMM, 3, 1, 0,    AMODE_DIR, 0, 1);
    drive(OP_PASS, 'h00, BSEL_IMM, 3, 0, 0,    AMODE_IND, 1, 0);
    drive(OP_PASS, 'h00, BSEL_MEM, 0, 0, 'h20, AMODE_DIR, 0, 1);

    // Indirect write that also rewrites its own address register
    drive(OP_PASS, 'h77, BSEL_IMM, 3, 1, 0,    AMODE_IND, 1, 1);
    drive(OP_PASS, 'h00, BSEL_REG, 3, 0, 0,    AMODE_DIR, 0, 1);
    drive(OP_PASS, 'h00, BSEL_MEM, 0, 0, 'h20, AMODE_DIR, 0, 1);

    // Simultaneous ACC and register writes store the old ACC
    drive(OP_PASS, 'h11, BSEL_IMM, 0, 0, 0, AMODE_DIR, 0, 1);
    drive(OP_ADD,  'h01, BSEL_IMM, 5, 1, 0, AMODE_DIR, 0, 1);
    drive(OP_PASS, 'h00, BSEL_REG, 5, 1, 0, AMODE_DIR, 0, 1);
    drive(OP_PASS, 'h00, BSEL_REG, 5, 0, 0, AMODE_DIR, 0, 1);

    // Compare leaves ACC alone
    drive(OP_PASS, 'h05, BSEL_IMM, 0, 0, 0, AMODE_DIR, 0, 1);
    drive(OP_CMP,  'h09, BSEL_IMM, 0, 0, 0, AMODE_DIR, 0, 1);
    drive(OP_CMP,  'h05, BSEL_IMM, 0, 0, 0, AMODE_DIR, 0, 1);

    // Increment / decrement wrap-around
    drive(OP_PASS, 'hFF, BSEL_IMM, 0, 0, 0, AMODE_DIR, 0, 1);
    drive(OP_INC,  'h00, BSEL_IMM, 0, 0, 0, AMODE_DIR, 0, 1);
    drive(OP_DEC,  'h00, BSEL_IMM, 0, 0, 0, AMODE_DIR, 0, 1);

    // Randomized control words
    for (int n = 0; n < 2000; n++) begin
      drive(int'($urandom_range(0, 15)), int'($urandom_range(0, 255)),
            int'($urandom_range(0, 3)), int'($urandom_range(0, 15)),
            bit'($urandom_range(0, 1)), int'($urandom_range(0, 255)),
            bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
            ($urandom_range(0, 3) != 0));
    end
    idle();

    // Reset held across an edge blocks every write
    RST_N = 1'b0;
    ALU_OUT = OP_PASS;
    IMM = 8'h55;
    IN_B_SEL = BSEL_IMM;
    REG_F_SEL = 4'd0;
    D_MEM_ADDR = 8'h00;
    D_MEM_ADDR_MODE = AMODE_DIR;
    EN_ACC = 1'b1;
    EN_REG_F = 1'b1;
    EN_D_MEM = 1'b1;
    @(posedge CLK);
    #1;
    chk("held_reset_acc", int'(ACC_OUT), 0);
    chk("held_reset_c", int'(FLAG_C), 0);
    @(negedge CLK);
    EN_ACC = 1'b0;
    EN_REG_F = 1'b0;
    EN_D_MEM = 1'b0;
    RST_N = 1'b1;
    model_reset();
    drive(OP_PASS, 0, BSEL_REG, 0, 0, 0, AMODE_DIR, 0, 1);
    drive(OP_PASS, 0, BSEL_MEM, 0, 0, 0, AMODE_DIR, 0, 1);
    idle();

    repeat (2) @(negedge CLK);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
